// File: rtl/red_iterativa_cargador_serie_if.sv
// ---------------------------------------------------------------------------
// red_iterativa_cargador_serie_if
// Handshake/bus bundle between the serial operand loader and its neighbours.
//   inicio      start pulse for a new load
//   bit_valido  qualifies a_bit/b_bit in the current cycle
//   a_bit/b_bit serial operand bits, LSB first
//   ack         consumer has taken A/B
//   A/B         assembled N-bit operands
//   listo       A/B complete and stable
//   ocupado     load in progress
// modport slave  : the loader itself
// modport master : the producer/consumer side driving the serial stream
// ---------------------------------------------------------------------------
interface red_iterativa_cargador_serie_if #(
    parameter int N = 32
);
    logic         inicio;
    logic         bit_valido;
    logic         a_bit;
    logic         b_bit;
    logic         ack;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         listo;
    logic         ocupado;

    modport master (
        output inicio, bit_valido, a_bit, b_bit, ack,
        input  A, B, listo, ocupado
    );

    modport slave (
        input  inicio, bit_valido, a_bit, b_bit, ack,
        output A, B, listo, ocupado
    );
endinterface

// File: rtl/red_iterativa_cargador_serie.sv
// ---------------------------------------------------------------------------
// red_iterativa_cargador_serie
// Bit-serial to parallel operand loader for the iterative comparator network.
// Operands A and B arrive LSB first on two 1-bit lines and are assembled into
// N-bit words, then offered to the comparator with a listo/ack handshake.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous reset, active low
//   bus    red_iterativa_cargador_serie_if.slave (inicio, bit_valido, a_bit,
//          b_bit, ack in; A, B, listo, ocupado out, all registered)
// ---------------------------------------------------------------------------
module red_iterativa_cargador_serie #(
    parameter int N = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    red_iterativa_cargador_serie_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        CARGA  = 2'd1,
        LISTO  = 2'd2
    } estado_t;

    estado_t       estado;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic [CW-1:0] count;
    logic          listo_reg;
    logic          ocupado_reg;

    // Single state machine with all outputs registered. Bits are shifted in
    // from the MSB end so the first bit received finishes in bit 0.
    // The edge that captures the N-th bit moves to LISTO; listo is raised one
    // edge later, so ack is only honoured once listo is actually visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado      <= REPOSO;
            a_reg       <= '0;
            b_reg       <= '0;
            count       <= '0;
            listo_reg   <= 1'b0;
            ocupado_reg <= 1'b0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (bus.inicio) begin
                        estado      <= CARGA;
                        a_reg       <= '0;
                        b_reg       <= '0;
                        count       <= '0;
                        ocupado_reg <= 1'b1;
                        listo_reg   <= 1'b0;
                    end
                end
                CARGA: begin
                    if (bus.inicio) begin
                        // Restart: bit_valido in this same cycle is dropped.
                        a_reg <= '0;
                        b_reg <= '0;
                        count <= '0;
                    end else if (bus.bit_valido) begin
                        a_reg <= {bus.a_bit, a_reg[N-1:1]};
                        b_reg <= {bus.b_bit, b_reg[N-1:1]};
                        count <= count + CW'(1);
                        if (count == CW'(N - 1)) begin
                            estado      <= LISTO;
                            ocupado_reg <= 1'b0;
                        end
                    end
                end
                LISTO: begin
                    // ack beats a simultaneous inicio; inicio is not latched.
                    if (listo_reg && bus.ack) begin
                        estado    <= REPOSO;
                        listo_reg <= 1'b0;
                    end else begin
                        listo_reg <= 1'b1;
                    end
                end
                default: begin
                    estado      <= REPOSO;
                    listo_reg   <= 1'b0;
                    ocupado_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.A       = a_reg;
    assign bus.B       = b_reg;
    assign bus.listo   = listo_reg;
    assign bus.ocupado = ocupado_reg;

endmodule

// File: tb/tb_red_iterativa_cargador_serie.sv
// ---------------------------------------------------------------------------
// tb_red_iterativa_cargador_serie
// Self-checking bench for the serial operand loader. Two instances are used:
// N = 32 for the main scenarios and N = 4 for the stall pattern and a
// per-cycle random model check. Expected values come from the words the
// bench chooses to send and from counting valid bits, not from the RTL.
// ---------------------------------------------------------------------------
module tb_red_iterativa_cargador_serie;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    red_iterativa_cargador_serie_if #(.N(32)) bus32 ();
    red_iterativa_cargador_serie_if #(.N(4))  bus4 ();

    red_iterativa_cargador_serie #(.N(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32)
    );

    red_iterativa_cargador_serie #(.N(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs on the 32-bit instance, then sample point.
    task automatic step32(input logic ini, input logic bv, input logic ab,
                          input logic bb, input logic ak);
        bus32.inicio     = ini;
        bus32.bit_valido = bv;
        bus32.a_bit      = ab;
        bus32.b_bit      = bb;
        bus32.ack        = ak;
        @(posedge clk);
        #1;
    endtask

    task automatic step4(input logic ini, input logic bv, input logic ab,
                         input logic bb, input logic ak);
        bus4.inicio     = ini;
        bus4.bit_valido = bv;
        bus4.a_bit      = ab;
        bus4.b_bit      = bb;
        bus4.ack        = ak;
        @(posedge clk);
        #1;
    endtask

    // inicio cycle followed by the 32 bits of wa/wb LSB first, optionally with
    // random idle (bit_valido = 0) cycles carrying junk data in between.
    task automatic load32(input logic [31:0] wa, input logic [31:0] wb,
                          input bit gaps, input logic bv_on_inicio);
        step32(1'b1, bv_on_inicio, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 32; i++) begin
            if (gaps) begin
                for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++)
                    step32(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'b0);
            end
            step32(1'b0, 1'b1, wa[i], wb[i], 1'b0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step32(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus32.A !== 32'h0 || bus32.B !== 32'h0 || bus32.listo !== 1'b0 || bus32.ocupado !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_initial: A=%h B=%h listo=%b ocupado=%b, required all 0",
                     bus32.A, bus32.B, bus32.listo, bus32.ocupado);
        end
        rst_n = 1'b1;
        step32(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Start a load of all-ones and abort it after 10 bits.
        step32(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step32(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bus32.ocupado !== 1'b1 || bus32.A !== 32'hFFC0_0000) begin
            errors++;
            $display("[TB] FAIL reset_preload: ocupado=%b A=%h, required 1 and ffc00000",
                     bus32.ocupado, bus32.A);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus32.A !== 32'h0 || bus32.B !== 32'h0 || bus32.listo !== 1'b0 || bus32.ocupado !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_async: A=%h B=%h listo=%b ocupado=%b, required all 0",
                     bus32.A, bus32.B, bus32.listo, bus32.ocupado);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        load32(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
        step32(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus32.listo !== 1'b1 || bus32.A !== 32'h5 || bus32.B !== 32'h3) begin
            errors++;
            $display("[TB] FAIL reset_reload: listo=%b A=%h B=%h, required 1 00000005 00000003",
                     bus32.listo, bus32.A, bus32.B);
        end
        step32(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_basic_load();
        logic [31:0] wa;
        logic [31:0] wb;
        wa = 32'hDEAD_BEEF;
        wb = 32'h1234_5678;
        load32(wa, wb, 1'b0, 1'b0);
        // 32 edges after inicio: last bit captured, listo not yet up.
        checks++;
        if (bus32.listo !== 1'b0 || bus32.ocupado !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_cycle32: listo=%b ocupado=%b, required 0 0",
                     bus32.listo, bus32.ocupado);
        end
        step32(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus32.listo !== 1'b1 || bus32.A !== wa || bus32.B !== wb) begin
            errors++;
            $display("[TB] FAIL basic_cycle33: listo=%b A=%h B=%h, required 1 %h %h",
                     bus32.listo, bus32.A, bus32.B, wa, wb);
        end
        step32(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_stall();
        bit          pv [7] = '{1, 0, 0, 1, 1, 0, 1};
        logic [3:0]  w;
        int          nvalid;
        w = 4'b1010;
        nvalid = 0;
        step4(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            if (pv[i]) begin
                step4(1'b0, 1'b1, w[nvalid], w[nvalid], 1'b0);
                nvalid++;
            end else begin
                step4(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'b0);
            end
            checks++;
            if (bus4.listo !== 1'b0 || bus4.ocupado !== (nvalid < 4)) begin
                errors++;
                $display("[TB] FAIL stall_step%0d: listo=%b ocupado=%b, required 0 %b",
                         i, bus4.listo, bus4.ocupado, (nvalid < 4));
            end
        end
        step4(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bus4.listo !== 1'b1 || bus4.A !== 4'hA || bus4.B !== 4'hA) begin
            errors++;
            $display("[TB] FAIL stall_result: listo=%b A=%h B=%h, required 1 a a",
                     bus4.listo, bus4.A, bus4.B);
        end
        step4(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_restart();
        logic [31:0] wa;
        logic [31:0] wb;
        wa = 32'h8000_0081;
        wb = 32'h0000_007F;
        step32(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step32(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        load32(wa, wb, 1'b0, 1'b1);
        checks++;
        if (bus32.listo !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_early: listo=%b, required 0", bus32.listo);
        end
        step32(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus32.listo !== 1'b1 || bus32.A !== wa || bus32.B !== wb) begin
            errors++;
            $display("[TB] FAIL restart_result: listo=%b A=%h B=%h, required 1 %h %h",
                     bus32.listo, bus32.A, bus32.B, wa, wb);
        end
        step32(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_hold_ack();
        logic [31:0] wa;
        logic [31:0] wb;
        wa = $urandom;
        wb = $urandom;
        load32(wa, wb, 1'b1, 1'b0);
        step32(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step32(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            checks++;
            if (bus32.listo !== 1'b1 || bus32.ocupado !== 1'b0 || bus32.A !== wa || bus32.B !== wb) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d: listo=%b ocupado=%b A=%h B=%h, required 1 0 %h %h",
                         i, bus32.listo, bus32.ocupado, bus32.A, bus32.B, wa, wb);
            end
        end
        step32(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (bus32.listo !== 1'b0 || bus32.A !== wa || bus32.B !== wb) begin
            errors++;
            $display("[TB] FAIL ack_drop: listo=%b A=%h B=%h, required 0 %h %h",
                     bus32.listo, bus32.A, bus32.B, wa, wb);
        end
        for (int i = 0; i < 3; i++) step32(1'b0, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
        checks++;
        if (bus32.A !== wa || bus32.B !== wb || bus32.ocupado !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ack_retain: A=%h B=%h ocupado=%b, required %h %h 0",
                     bus32.A, bus32.B, bus32.ocupado, wa, wb);
        end
    endtask

    task automatic test_collision();
        logic [31:0] wa;
        logic [31:0] wb;
        wa = $urandom;
        wb = $urandom;
        load32(wa, wb, 1'b0, 1'b0);
        step32(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step32(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus32.listo !== 1'b0 || bus32.ocupado !== 1'b0) begin
            errors++;
            $display("[TB] FAIL collision_edge: listo=%b ocupado=%b, required 0 0",
                     bus32.listo, bus32.ocupado);
        end
        step32(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step32(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bus32.ocupado !== 1'b0 || bus32.listo !== 1'b0 || bus32.A !== wa || bus32.B !== wb) begin
            errors++;
            $display("[TB] FAIL collision_noload: ocupado=%b listo=%b A=%h B=%h, required 0 0 %h %h",
                     bus32.ocupado, bus32.listo, bus32.A, bus32.B, wa, wb);
        end
    endtask

    // Random gaps and words on both instances; on N = 4 the status outputs are
    // predicted every cycle from a count of valid bits since inicio.
    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            logic [31:0] wa;
            logic [31:0] wb;
            wa = $urandom;
            wb = $urandom;
            load32(wa, wb, 1'b1, 1'b0);
            step32(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (bus32.listo !== 1'b1 || bus32.A !== wa || bus32.B !== wb) begin
                errors++;
                $display("[TB] FAIL random32_%0d: listo=%b A=%h B=%h, required 1 %h %h",
                         r, bus32.listo, bus32.A, bus32.B, wa, wb);
            end
            step32(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        for (int r = 0; r < 6; r++) begin
            logic [3:0] wa;
            logic [3:0] wb;
            int         nvalid;
            int         guard;
            wa = 4'($urandom);
            wb = 4'($urandom);
            nvalid = 0;
            guard = 0;
            step4(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            while (nvalid < 4 && guard < 40) begin
                logic bv;
                bv = 1'($urandom);
                guard++;
                if (bv) begin
                    step4(1'b0, 1'b1, wa[nvalid], wb[nvalid], 1'b0);
                    nvalid++;
                end else begin
                    step4(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
                end
                checks++;
                if (bus4.listo !== 1'b0 || bus4.ocupado !== (nvalid < 4)) begin
                    errors++;
                    $display("[TB] FAIL random4_%0d_status: listo=%b ocupado=%b, required 0 %b",
                             r, bus4.listo, bus4.ocupado, (nvalid < 4));
                end
            end
            step4(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (bus4.listo !== (nvalid == 4) || bus4.A !== wa || bus4.B !== wb) begin
                errors++;
                $display("[TB] FAIL random4_%0d: listo=%b A=%h B=%h, required 1 %h %h",
                         r, bus4.listo, bus4.A, bus4.B, wa, wb);
            end
            step4(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus4.inicio = 1'b0;
        bus4.bit_valido = 1'b0;
        bus4.a_bit = 1'b0;
        bus4.b_bit = 1'b0;
        bus4.ack = 1'b0;
        $display("[TB] starting");
        test_reset();
        test_basic_load();
        test_stall();
        test_restart();
        test_hold_ack();
        test_collision();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
